// File: rtl/icache_line_fill_pkg.sv
// Shared types for the I-cache line fill engine: the 256-bit line and the fill FSM states.
package icache_line_fill_pkg;

   localparam int unsigned LINE_BITS = 256;

   typedef logic [LINE_BITS-1:0] icache_line_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } icfill_state_t;

   // Counter width that never collapses to zero bits when only one beat is needed.
   function automatic int unsigned clog2_min1(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/icache_line_fill.sv
// I-cache line fill: fetches a 32-byte line as ascending bus beats and writes it to the line SRAM.
// Optional beat watchdog enabled by defining ICFILL_TIMEOUT_EN.
module icache_line_fill
   import icache_line_fill_pkg::*;
#(
   parameter int unsigned BUS_WIDTH  = 64,
   parameter int unsigned TMO_CYCLES = 1023
)(
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_miss_req,
   input  logic [31:0]          i_miss_adr,
   output logic                 o_miss_ack,
   output logic                 o_bus_req,
   output logic [31:0]          o_bus_adr,
   input  logic                 i_bus_ack,
   input  logic                 i_bus_err,
   input  logic [BUS_WIDTH-1:0] i_bus_dat,
   output logic                 o_sram_wr,
   output logic [9:0]           o_sram_wadr,
   output logic [255:0]         o_sram_i,
   output logic                 o_fill_done,
   output logic                 o_fill_err,
   output logic                 o_busy
);

   localparam int unsigned NBEATS     = LINE_BITS / BUS_WIDTH;
   localparam int unsigned CNT_W      = clog2_min1(NBEATS);
   localparam int unsigned BEAT_BYTES = BUS_WIDTH / 8;

   generate
      if (!(BUS_WIDTH == 64 || BUS_WIDTH == 128 || BUS_WIDTH == 256) || TMO_CYCLES < 1) begin : g_bad_cfg
         $error("icache_line_fill: illegal BUS_WIDTH or TMO_CYCLES");
      end
   endgenerate

   icfill_state_t      r_state;
   icfill_state_t      w_state_next;
   logic [26:0]        r_base;
   logic [CNT_W-1:0]   r_cnt;
   icache_line_t       r_line;
   logic               w_last;
   logic               w_tmo_hit;
   logic               w_abort;
   logic               w_beat_we;
   logic [4:0]         w_offset;
   logic [4:0]         w_unused_adr_bits;

   assign w_unused_adr_bits = i_miss_adr[4:0];
   assign w_last    = (r_cnt == CNT_W'(NBEATS - 1));
   assign w_abort   = (r_state == REQ) && (i_bus_err || w_tmo_hit);
   assign w_beat_we = (r_state == REQ) && i_bus_ack && !w_abort;
   assign w_offset  = 5'(r_cnt * BEAT_BYTES);

`ifdef ICFILL_TIMEOUT_EN
   localparam int unsigned TMO_W = $clog2(TMO_CYCLES + 1);
   logic [TMO_W-1:0] r_tmo;

   // Held at zero outside REQ so every REQ entry starts a fresh count.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         r_tmo <= '0;
      else if (r_state != REQ || i_bus_ack)
         r_tmo <= '0;
      else
         r_tmo <= r_tmo + 1'b1;
   end

   assign w_tmo_hit = (r_state == REQ) && (r_tmo == TMO_W'(TMO_CYCLES));
`else
   assign w_tmo_hit = 1'b0;
`endif

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         r_state <= IDLE;
      else
         r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      o_miss_ack   = 1'b0;
      o_fill_err   = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (i_miss_req) begin
               o_miss_ack   = 1'b1;
               w_state_next = REQ;
            end
         end
         REQ: begin
            if (w_abort) begin
               o_fill_err   = 1'b1;
               w_state_next = IDLE;
            end else if (i_bus_ack && w_last) begin
               w_state_next = WRITE;
            end
         end
         WRITE:   w_state_next = DONE;
         DONE:    w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_base <= '0;
         r_cnt  <= '0;
      end else if (r_state == IDLE && i_miss_req) begin
         r_base <= i_miss_adr[31:5];
         r_cnt  <= '0;
      end else if (w_beat_we && !w_last) begin
         r_cnt  <= r_cnt + 1'b1;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_line <= '0;
      end else begin
         for (int b = 0; b < NBEATS; b++) begin
            if (w_beat_we && r_cnt == CNT_W'(b))
               r_line[b*BUS_WIDTH +: BUS_WIDTH] <= i_bus_dat;
         end
      end
   end

   // The line base has zero low bits, so the in-line offset can be concatenated.
   assign o_bus_adr   = {r_base, w_offset};
   assign o_bus_req   = (r_state == REQ);
   assign o_sram_wr   = (r_state == WRITE);
   assign o_sram_wadr = r_base[9:0];
   assign o_sram_i    = r_line;
   assign o_fill_done = (r_state == DONE);
   assign o_busy      = (r_state != IDLE);

endmodule

// File: tb/tb_icache_line_fill.sv
// Directed/random bench for icache_line_fill (BUS_WIDTH=64); timeout case runs when ICFILL_TIMEOUT_EN is defined.
module tb_icache_line_fill;

   localparam int BW     = 64;
   localparam int NB     = 256 / BW;
   localparam int TMO    = 16;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          miss_req;
   logic [31:0]   miss_adr;
   logic          miss_ack;
   logic          bus_req;
   logic [31:0]   bus_adr;
   logic          bus_ack;
   logic          bus_err;
   logic [BW-1:0] bus_dat;
   logic          sram_wr;
   logic [9:0]    sram_wadr;
   logic [255:0]  sram_i;
   logic          fill_done;
   logic          fill_err;
   logic          busy;

   int n_assert = 0;
   int n_fail   = 0;
   int wr_count = 0;
   int overlap  = 0;
   int done_bad = 0;
   int n_ok     = 0;
   logic prev_wr = 1'b0;

   icache_line_fill #(.BUS_WIDTH(BW), .TMO_CYCLES(TMO)) dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_miss_req  (miss_req),
      .i_miss_adr  (miss_adr),
      .o_miss_ack  (miss_ack),
      .o_bus_req   (bus_req),
      .o_bus_adr   (bus_adr),
      .i_bus_ack   (bus_ack),
      .i_bus_err   (bus_err),
      .i_bus_dat   (bus_dat),
      .o_sram_wr   (sram_wr),
      .o_sram_wadr (sram_wadr),
      .o_sram_i    (sram_i),
      .o_fill_done (fill_done),
      .o_fill_err  (fill_err),
      .o_busy      (busy)
   );

   always #5 clk = ~clk;

   // Protocol monitor: counts writes, write/request overlap and misplaced done pulses.
   always @(negedge clk) begin
      if (sram_wr === 1'b1) wr_count++;
      if (sram_wr === 1'b1 && bus_req === 1'b1) overlap++;
      if (rst_n === 1'b1 && fill_done !== prev_wr) done_bad++;
      prev_wr = (sram_wr === 1'b1);
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   task automatic chk(input logic [255:0] obs, input logic [255:0] exp, input string tag);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One fill transaction. err_beat/rst_beat < 0 disable that fault.
   task automatic do_fill(input logic [31:0] adr, input int max_wait, input int err_beat,
                          input int rst_beat, input bit hold_req, input bit chk_lat, input string tag);
      logic [BW-1:0]  beat [NB];
      logic [255:0]   exp_line;
      logic [31:0]    base;
      int             cyc;
      int             wr_before;
      int             w;
      base      = adr & 32'hFFFF_FFE0;
      wr_before = wr_count;
      for (int b = 0; b < NB; b++) begin
         beat[b] = {$urandom, $urandom};
         exp_line[b*BW +: BW] = beat[b];
      end
      miss_adr = adr;
      miss_req = 1'b1;
      #1;
      chk(miss_ack, 1'b1, {tag, "_miss_ack"});
      step();
      cyc = 1;
      if (hold_req) miss_adr = adr ^ 32'h1000_0000;
      else          miss_req = 1'b0;
      for (int b = 0; b < NB; b++) begin
         w = $urandom_range(0, max_wait);
         for (int i = 0; i < w; i++) begin
            #1;
            chk(bus_req, 1'b1, {tag, "_req_wait"});
            chk(bus_adr, base + 32'(b * (BW / 8)), {tag, "_adr_wait"});
            chk(miss_ack, 1'b0, {tag, "_no_reack"});
            step();
            cyc++;
         end
         if (b == rst_beat) begin
            rst_n    = 1'b0;
            miss_req = 1'b0;
            #1;
            chk(busy, 1'b0, {tag, "_rst_busy"});
            chk(bus_req, 1'b0, {tag, "_rst_req"});
            chk(sram_i, 256'h0, {tag, "_rst_line"});
            step();
            rst_n = 1'b1;
            repeat (3) step();
            chk(32'(wr_count), 32'(wr_before), {tag, "_rst_nowr"});
            chk(busy, 1'b0, {tag, "_rst_idle"});
            return;
         end
         bus_dat = beat[b];
         bus_ack = 1'b1;
         bus_err = (b == err_beat);
         #1;
         chk(bus_req, 1'b1, {tag, "_req"});
         chk(bus_adr, base + 32'(b * (BW / 8)), {tag, "_adr"});
         chk(fill_err, (b == err_beat), {tag, "_err_pulse"});
         step();
         cyc++;
         bus_ack = 1'b0;
         bus_err = 1'b0;
         if (b == err_beat) begin
            miss_req = 1'b0;
            #1;
            chk(busy, 1'b0, {tag, "_err_busy"});
            chk(bus_req, 1'b0, {tag, "_err_req"});
            repeat (2) step();
            chk(32'(wr_count), 32'(wr_before), {tag, "_err_nowr"});
            return;
         end
      end
      miss_req = 1'b0;
      #1;
      chk(sram_wr, 1'b1, {tag, "_sram_wr"});
      chk(bus_req, 1'b0, {tag, "_wr_noreq"});
      chk(sram_wadr, base[14:5], {tag, "_wadr"});
      chk(sram_i, exp_line, {tag, "_line"});
      if (chk_lat) chk(32'(cyc), 32'(NB + 1), {tag, "_latency"});
      step();
      chk(fill_done, 1'b1, {tag, "_done"});
      chk(sram_wr, 1'b0, {tag, "_wr_once"});
      step();
      chk(busy, 1'b0, {tag, "_idle"});
      chk(32'(wr_count), 32'(wr_before + 1), {tag, "_wr_count"});
      $display("fill %s adr=%08h wadr=%03h done", tag, adr, base[14:5]);
      n_ok++;
   endtask

   initial begin
      rst_n    = 1'b0;
      miss_req = 1'b0;
      miss_adr = '0;
      bus_ack  = 1'b0;
      bus_err  = 1'b0;
      bus_dat  = '0;
      #12;
      chk(busy, 1'b0, "rst_busy");
      chk(bus_req, 1'b0, "rst_bus_req");
      chk(sram_wr, 1'b0, "rst_sram_wr");
      chk(fill_done, 1'b0, "rst_done");
      chk(fill_err, 1'b0, "rst_err");
      chk(miss_ack, 1'b0, "rst_ack");
      chk(bus_adr, 32'h0, "rst_bus_adr");
      chk(sram_wadr, 10'h0, "rst_wadr");
      chk(sram_i, 256'h0, "rst_line");
      #4;
      rst_n = 1'b1;
      step();

      do_fill(32'h0001_2345, 0, -1, -1, 1'b0, 1'b1, "t1");
      for (int k = 0; k < 4; k++) do_fill($urandom, 5, -1, -1, 1'b1, 1'b0, "t2");
      do_fill($urandom, 2, 2, -1, 1'b0, 1'b0, "t3err");
      do_fill($urandom, 0, -1, -1, 1'b0, 1'b1, "t3next");
      do_fill($urandom, 1, -1, 1, 1'b0, 1'b0, "t4rst");
      do_fill($urandom, 3, -1, -1, 1'b0, 1'b0, "t4next");
      do_fill(32'hFFFF_FFE0, 0, -1, -1, 1'b0, 1'b1, "t5");

`ifdef ICFILL_TIMEOUT_EN
      begin
         int k;
         miss_adr = $urandom;
         miss_req = 1'b1;
         step();
         miss_req = 1'b0;
         k = 0;
         while (k < 100) begin
            #1;
            if (fill_err === 1'b1) break;
            step();
            k++;
         end
         chk(32'(k), 32'(TMO), "t6_timeout_cycles");
         step();
         chk(busy, 1'b0, "t6_idle");
         $display("timeout fill_err after %0d cycles", k);
      end
`endif

      repeat (2) step();
      chk(32'(wr_count), 32'(n_ok), "total_writes");
      chk(32'(overlap), 32'h0, "wr_req_overlap");
      chk(32'(done_bad), 32'h0, "done_after_wr");
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
